uart_digest_tx: RTL

UART_DIGEST_TX -- requirements
Module: uart_digest_tx

---
 rtl/uart_digest_tx_if.sv | 24 ++
 rtl/uart_digest_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_digest_tx_if.sv
// Handshake and serial-line bundle for the digest transmitter.
// The master side (host logic / bench) supplies the baud tick, the start
// request and the word; the slave side (the transmitter) returns the line
// and its status.
interface uart_digest_tx_if #(
  parameter int NBYTES = 20
);
  logic                  s_tick;
  logic                  start;
  logic [8*NBYTES-1:0]   din;
  logic                  tx;
  logic                  busy;
  logic                  done_tick;

  modport master (
    output s_tick, start, din,
    input  tx, busy, done_tick
  );

  modport slave (
    input  s_tick, start, din,
    output tx, busy, done_tick
  );
endinterface

// File: rtl/uart_digest_tx.sv
// Multi-byte 8N1 UART transmitter: latches an NBYTES-wide word on start and
// sends it most-significant byte first, each byte LSB first, with no idle gap
// between bytes. Timing is driven by a 16x oversampling baud tick.
module uart_digest_tx #(
  parameter int NBYTES  = 20,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_digest_tx_if.slave bus
);

  localparam int W  = 8 * NBYTES;
  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick, tick_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [BW-1:0]   byte_cnt, byte_cnt_n;
  logic [W-1:0]    word, word_n;
  logic            tx_q, tx_n;
  logic            done_q, done_n;
  logic [7:0]      cur_byte_n;

  // State, counters, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      word     <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      word     <= word_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  // Next-state logic; every counter holds unless s_tick is high.
  always_comb begin
    state_n    = state;
    tick_n     = tick;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    word_n     = word;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        // A start coinciding with the done pulse is the tail of the previous
        // request and is deliberately not taken; the tick in the accepting
        // cycle is not counted either.
        if (bus.start && !done_q) begin
          word_n     = bus.din;
          tick_n     = '0;
          bit_cnt_n  = '0;
          byte_cnt_n = '0;
          state_n    = START;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (tick == TW'(15)) begin
            tick_n  = '0;
            state_n = DATA;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (tick == TW'(15)) begin
            tick_n = '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt_n = '0;
              state_n   = STOP;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end

      STOP: begin
        if (bus.s_tick) begin
          if (tick == TW'(SB_TICK - 1)) begin
            tick_n = '0;
            if (byte_cnt == BW'(NBYTES - 1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              // Next byte moves into the top lane; restart framing at once.
              byte_cnt_n = byte_cnt + BW'(1);
              word_n     = word << 8;
              state_n    = START;
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Line level for the next cycle, derived from where the FSM is going so
  // tx can be a plain register with no decode glitches.
  always_comb begin
    cur_byte_n = word_n[W-1 -: 8];
    tx_n       = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte_n[bit_cnt_n];
      default: tx_n = 1'b1;
    endcase
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done_tick = done_q;

endmodule
